// File: rtl/vregfile_multiport.sv
// vregfile_multiport
//   Vector-lane register file with NUMREADPORTS registered read ports and a
//   single byte-lane-masked write port. A clear engine zeroes one register per
//   cycle after reset or on a clr pulse. While it runs, busy is high, writes
//   are dropped and enabled reads load zero.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-high; restarts the clear sequence
//   clr            pulse in IDLE starts a clear of every register
//   busy           high while the clear sequence is running
//   a_reg          read addresses, port p at [p*LOG2NUMREGS +: LOG2NUMREGS]
//   a_en           per-port read enable; a disabled port holds its output
//   a_readdataout  read data, port p at [p*WIDTH +: WIDTH], one-cycle latency
//   c_reg          write address
//   c_writedatain  write data
//   c_we           write enable
//   c_byteen       per-lane write mask, lane width WIDTH/NUMLANES
module vregfile_multiport #(
  parameter int WIDTH        = 32,
  parameter int NUMREGS      = 16,
  parameter int LOG2NUMREGS  = 4,
  parameter int NUMREADPORTS = 2,
  parameter int NUMLANES     = 4,
  parameter int BYPASS       = 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                clr,
  output logic                                busy,
  input  logic [NUMREADPORTS*LOG2NUMREGS-1:0] a_reg,
  input  logic [NUMREADPORTS-1:0]             a_en,
  output logic [NUMREADPORTS*WIDTH-1:0]       a_readdataout,
  input  logic [LOG2NUMREGS-1:0]              c_reg,
  input  logic [WIDTH-1:0]                    c_writedatain,
  input  logic                                c_we,
  input  logic [NUMLANES-1:0]                 c_byteen
);

  localparam int LANEW = WIDTH / NUMLANES;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  localparam logic [LOG2NUMREGS-1:0] LAST = LOG2NUMREGS'(NUMREGS - 1);

  logic [0:0]             state_q, state_d;
  logic [LOG2NUMREGS-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]       mem_q [NUMREGS];
  logic [WIDTH-1:0]       mem_d [NUMREGS];
  logic [WIDTH-1:0]       rd_q  [NUMREADPORTS];
  logic [WIDTH-1:0]       rd_d  [NUMREADPORTS];
  logic [WIDTH-1:0]       lane_mask;
  logic                   wr_in_range;
  logic                   wr_ok;

  assign busy = (state_q == CLEAR);

  // Clear sequencer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (cnt_q == LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Expand the per-lane byte enables to a bit mask
  always_comb begin
    lane_mask = '0;
    for (int unsigned l = 0; l < NUMLANES; l++) begin
      lane_mask[l*LANEW +: LANEW] = {LANEW{c_byteen[l]}};
    end
  end

  assign wr_in_range = (32'(c_reg) < 32'(NUMREGS));
  assign wr_ok       = c_we && !busy && wr_in_range;

  // Next storage contents. The clear step only advances when reset is low,
  // so holding reset never zeroes anything beyond register 0's turn.
  always_comb begin
    mem_d = mem_q;
    if (busy && !reset) begin
      mem_d[cnt_q] = '0;
    end else if (wr_ok) begin
      mem_d[c_reg] = (mem_q[c_reg] & ~lane_mask) | (c_writedatain & lane_mask);
    end
  end

  // Read ports. With bypass the port samples the post-write value of the
  // addressed register, which is exactly the lane merge on a collision.
  always_comb begin
    for (int unsigned p = 0; p < NUMREADPORTS; p++) begin
      logic [LOG2NUMREGS-1:0] ra;
      ra      = a_reg[p*LOG2NUMREGS +: LOG2NUMREGS];
      rd_d[p] = rd_q[p];
      if (a_en[p]) begin
        if (busy || !(32'(ra) < 32'(NUMREGS))) begin
          rd_d[p] = '0;
        end else if (BYPASS != 0) begin
          rd_d[p] = mem_d[ra];
        end else begin
          rd_d[p] = mem_q[ra];
        end
      end
    end
  end

  always_comb begin
    a_readdataout = '0;
    for (int unsigned p = 0; p < NUMREADPORTS; p++) begin
      a_readdataout[p*WIDTH +: WIDTH] = rd_q[p];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      for (int unsigned p = 0; p < NUMREADPORTS; p++) begin
        rd_q[p] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
    end
  end

  // Storage has no reset; the clear sequence that follows reset zeroes it.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_vregfile_multiport.sv
// tb_vregfile_multiport
//   Self-checking bench for vregfile_multiport (default parameters).
//   A behavioural model (register array plus a count of remaining clear
//   cycles) is compared against the DUT after every clock edge; constant
//   vectors and hand sequences cover the documented scenarios.
module tb_vregfile_multiport;

  localparam int BYPASS = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        clr;
  logic        busy;
  logic [7:0]  a_reg;
  logic [1:0]  a_en;
  logic [63:0] a_readdataout;
  logic [3:0]  c_reg;
  logic [31:0] c_writedatain;
  logic        c_we;
  logic [3:0]  c_byteen;

  int n_checks = 0;
  int n_fail   = 0;

  vregfile_multiport #(
    .WIDTH(32), .NUMREGS(16), .LOG2NUMREGS(4),
    .NUMREADPORTS(2), .NUMLANES(4), .BYPASS(BYPASS)
  ) dut (
    .clk(clk), .reset(reset), .clr(clr), .busy(busy),
    .a_reg(a_reg), .a_en(a_en), .a_readdataout(a_readdataout),
    .c_reg(c_reg), .c_writedatain(c_writedatain), .c_we(c_we),
    .c_byteen(c_byteen)
  );

  always #5 clk = ~clk;

  // Reference model
  logic [31:0] mm [16];
  logic [31:0] m_rd [2];
  int          clear_left = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [31:0] old [16];
    logic [31:0] mask;
    bit          was_busy;
    old      = mm;
    was_busy = (clear_left > 0);
    mask     = 0;
    for (int l = 0; l < 4; l++) if (c_byteen[l]) mask = mask | (32'hFF << (8*l));
    if (c_we && !was_busy) mm[c_reg] = (old[c_reg] & ~mask) | (c_writedatain & mask);
    if (reset) begin
      m_rd[0] = 0;
      m_rd[1] = 0;
      clear_left = 16;
    end else begin
      for (int p = 0; p < 2; p++) begin
        logic [3:0] ad;
        ad = a_reg[p*4 +: 4];
        if (a_en[p]) m_rd[p] = was_busy ? 32'h0 : (BYPASS != 0 ? mm[ad] : old[ad]);
      end
      if (was_busy) begin
        mm[16 - clear_left] = 0;
        clear_left--;
      end else if (clr) begin
        clear_left = 16;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("model_busy", {31'b0, busy}, {31'b0, clear_left > 0});
    check("model_port0", a_readdataout[31:0], m_rd[0]);
    check("model_port1", a_readdataout[63:32], m_rd[1]);
  endtask

  task automatic idle_inputs();
    clr = 0; c_we = 0; a_en = 0; a_reg = 0; c_reg = 0;
    c_writedatain = 0; c_byteen = 0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic write_reg(input logic [3:0] r, input logic [31:0] d);
    c_we = 1; c_reg = r; c_writedatain = d; c_byteen = 4'hF;
    tick();
    c_we = 0;
  endtask

  task automatic read_all_zero(input string name);
    for (int r = 0; r < 16; r++) begin
      a_en  = 2'b11;
      a_reg = {r[3:0], r[3:0]};
      tick();
      check(name, a_readdataout[31:0], 32'h0);
      check(name, a_readdataout[63:32], 32'h0);
    end
    a_en = 0;
  endtask

  typedef struct {
    bit          we;
    logic [3:0]  creg;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [1:0]  en;
    logic [3:0]  r0;
    logic [3:0]  r1;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int n;
    for (int i = 0; i < 16; i++) mm[i] = 0;
    m_rd[0] = 0;
    m_rd[1] = 0;

    tbl[0] = '{1'b1, 4'd5, 32'hDEADBEEF, 4'hF,    2'b00, 4'd0, 4'd0, 32'h0, 32'h0};
    tbl[1] = '{1'b1, 4'd5, 32'h11223344, 4'b0101, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0};
    tbl[2] = '{1'b0, 4'd0, 32'h0,        4'h0,    2'b01, 4'd5, 4'd0, 32'hDE22BE44, 32'h0};
    tbl[3] = '{1'b0, 4'd0, 32'h0,        4'h0,    2'b00, 4'd0, 4'd0, 32'hDE22BE44, 32'h0};
    tbl[4] = '{1'b1, 4'd7, 32'hAAAAAAAA, 4'hF,    2'b00, 4'd0, 4'd0, 32'hDE22BE44, 32'h0};
    tbl[5] = '{1'b1, 4'd7, 32'h55555555, 4'b0011, 2'b01, 4'd7, 4'd0,
               (BYPASS != 0) ? 32'hAAAA5555 : 32'hAAAAAAAA, 32'h0};
    tbl[6] = '{1'b1, 4'd1, 32'h1,        4'hF,    2'b00, 4'd0, 4'd0, tbl[5].e0, 32'h0};
    tbl[7] = '{1'b1, 4'd2, 32'h2,        4'hF,    2'b00, 4'd0, 4'd0, tbl[5].e0, 32'h0};
    tbl[8] = '{1'b0, 4'd0, 32'h0,        4'h0,    2'b11, 4'd1, 4'd2, 32'h1, 32'h2};
    tbl[9] = '{1'b0, 4'd0, 32'h0,        4'h0,    2'b10, 4'd0, 4'd1, 32'h1, 32'h1};

    idle_inputs();
    reset = 1;

    // Reset, then the post-reset clear sequence
    repeat (3) tick();
    check("reset_busy", {31'b0, busy}, 32'h1);
    check("reset_rd0", a_readdataout[31:0], 32'h0);
    reset = 0;
    wait_idle(n);
    check("reset_busy_cycles", n, 16);
    read_all_zero("reset_read_zero");

    // Constant vectors: lane merge, hold, collision, independent ports
    for (int i = 0; i < 10; i++) begin
      c_we = tbl[i].we; c_reg = tbl[i].creg; c_writedatain = tbl[i].wd;
      c_byteen = tbl[i].be; a_en = tbl[i].en; a_reg = {tbl[i].r1, tbl[i].r0};
      tick();
      check($sformatf("vec%0d_port0", i), a_readdataout[31:0], tbl[i].e0);
      check($sformatf("vec%0d_port1", i), a_readdataout[63:32], tbl[i].e1);
    end
    idle_inputs();

    // Clear request with a dropped write and a read during busy
    write_reg(4'd3, 32'h5);
    clr = 1;
    tick();
    clr = 0;
    check("clr_busy_start", {31'b0, busy}, 32'h1);
    c_we = 1; c_reg = 4'd3; c_writedatain = 32'h9; c_byteen = 4'hF;
    a_en = 2'b01; a_reg = 8'h03;
    tick();
    check("busy_read_zero", a_readdataout[31:0], 32'h0);
    idle_inputs();
    clr = 1;
    tick();
    clr = 0;
    wait_idle(n);
    check("clr_busy_cycles", n + 2, 16);
    a_en = 2'b01; a_reg = 8'h03;
    tick();
    check("clr_r3_zero", a_readdataout[31:0], 32'h0);
    idle_inputs();

    // Reset mid-clear restarts the full count
    for (int r = 0; r < 16; r++) write_reg(r[3:0], 32'hC0DE0000 | r);
    clr = 1;
    tick();
    clr = 0;
    repeat (7) tick();
    reset = 1;
    tick();
    reset = 0;
    wait_idle(n);
    check("restart_busy_cycles", n, 16);
    read_all_zero("restart_read_zero");

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      reset         = ($urandom_range(0, 249) == 0);
      clr           = ($urandom_range(0, 59) == 0);
      c_we          = ($urandom_range(0, 2) != 0);
      c_reg         = 4'($urandom_range(0, 15));
      c_writedatain = $urandom;
      c_byteen      = 4'($urandom_range(0, 15));
      a_en          = 2'($urandom_range(0, 3));
      a_reg         = 8'($urandom_range(0, 255));
      tick();
    end
    idle_inputs();
    reset = 0;
    wait_idle(n);
    check("final_idle", {31'b0, busy}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
